simd_data_mem: RTL
==================

# simd_data_mem

Responder side of the SIMD processor's 256-bit data-memory interface. It services `rden_RAM`/`wren_RAM` requests with per-byte write enables and returns 256-bit lines with one cycle of read latency. It also provides a low-priority 32-bit host port for loading and unloading data while the processor's memory stage is idle. It sits beside `simd_processor` in the SoC top, wired directly to its `*_RAM` ports.

## Interface
Parameters:
- `DEPTH`, default 1024: number of 256-bit lines.
- `ADDR_W`, default 10: line-index width, equal to $clog2(DEPTH).

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `address_RAM`, in, 32: byte address. Bits [4:0] are ignored; the line index is bits [ADDR_W+4:5].
- `byteena_RAM`, in, 32: bit i enables byte `writeData_RAM[8i+7:8i]`.
- `writeData_RAM`, in, 256: write line.
- `rden_RAM`, in, 1: processor read request.
- `wren_RAM`, in, 1: processor write request.
- `readData_RAM`, out, 256: read line, registered.
- `host_req`, in, 1: host access request.
- `host_we`, in, 1: 1 = write, 0 = read.
- `host_addr`, in, 32: byte address. Word select is [4:2]; line index is [ADDR_W+4:5].
- `host_wdata`, in, 32: host write word.
- `host_ready`, out, 1: host request accepted when `host_req && host_ready`.
- `host_rvalid`, out, 1: one-cycle pulse; `host_rdata` is valid while it is high.
- `host_rdata`, out, 32: host read word, registered.

## Operation
- **Storage:** 8 lanes of 32 bits × DEPTH. Lane k holds line bits [32k+31:32k].
- **Processor write:** when `wren_RAM` is high, at the edge, for each i with `byteena_RAM[i]` set, byte i of the addressed line takes `writeData_RAM` byte i. Other bytes are unchanged.
- **Processor read:** when `rden_RAM` is high, the addressed line is registered into `readData_RAM` at the edge. When `rden_RAM` is low, `readData_RAM` holds its value.
- **Same-cycle read and write to the same line:** read-first. `readData_RAM` returns the pre-write contents.
- **Out-of-range addresses** (line index ≥ DEPTH, or any address bits above ADDR_W+4 set): reads return all zeros and writes are dropped.
- **Arbitration:** the processor always wins.
  - `host_ready = !reset && !rden_RAM && !wren_RAM && state==IDLE`.
  - The host must hold `host_req`, `host_we`, `host_addr` and `host_wdata` stable until accepted.
- **Host write:** on accept, lane `host_addr[4:2]` of the line takes `host_wdata` with all 4 bytes written. Completes in the accept cycle; no `host_rvalid`.
- **Host read:** on accept, the selected 32-bit word is registered into `host_rdata`, and the FSM moves IDLE→RESP.
- **Host FSM:**
  - IDLE: `host_rvalid`=0.
  - RESP: `host_rvalid`=1 and `host_ready`=0. Returns to IDLE unconditionally after one cycle.
- Host out-of-range addresses follow the processor rule: reads return 0 and writes are dropped.

## Timing
- **Processor read latency:** 1 cycle. `rden_RAM` at edge N gives `readData_RAM` valid after edge N, usable in cycle N+1.
- **Host read latency:** 1 cycle. Accept at edge N gives `host_rvalid`=1 in cycle N+1. Back-to-back host reads are accepted every 2 cycles at most.
- **Host write throughput:** 1 per cycle while the processor is idle.
- **Reset values:** `readData_RAM`=0, `host_rdata`=0, `host_rvalid`=0, FSM=IDLE. `host_ready`=0 during reset.
- **Memory contents are not cleared by reset.**
- **Reset mid-operation:**
  - A host read accepted in the cycle before reset produces no `host_rvalid`.
  - Writes at an edge where `reset`=1 are dropped.

## Configuration
- `SIMD_DATA_MEM_HOST_EN`
  - **Defined:** the host port operates as described.
  - **Undefined:** the host logic and FSM are not compiled. `host_ready`, `host_rvalid` and `host_rdata` are tied to 0, and host inputs are ignored. Processor behaviour is identical in both builds.

## Structure
- `simd_mem_pkg` holds the following:
  - `LINE_W`=256, `LANES`=8, `LANE_W`=32.
  - Typedef `line_t` (logic [255:0]) and `byteen_t` (logic [31:0]).
  - Host FSM enum `host_state_e` {IDLE, RESP}.
  - Function `line_idx(addr)` returning the line index plus an in-range flag.
- One sub-module, `simd_mem_lane`: one 32-bit × DEPTH lane with 4 byte enables and read-first registered read. It is instantiated 8 times.
- Host word muxing and the FSM live in `simd_data_mem`.

## Test plan
- **Reset:** hold `reset` for 2 cycles → `readData_RAM`=0, `host_rvalid`=0, `host_ready`=0. After release, `host_ready`=1 with the processor idle.
- **Partial write then read:** write line 3 with all bytes = 0xAA, then `byteena_RAM`=0x0000_000F with `writeData_RAM` = 0x11223344 in bytes 3..0. Read 0x60 → readData[31:0]=0x11223344 and bytes 31..4 = 0xAA, one cycle after `rden_RAM`.
- **Read-first collision:** line 5 holds 0. Assert `rden_RAM` and `wren_RAM` together at 0xA0 with all-ones data → readData=0. The following read returns all-ones.
- **Host arbitration:**
  - `host_req` held while the processor asserts `rden_RAM` for 3 cycles → `host_ready`=0 for those 3 cycles, then accepted.
  - A host read of 0xA4 after the collision write → `host_rvalid` 1 cycle later with `host_rdata`=0xFFFFFFFF.
- **Out of range:** with DEPTH=1024, write at 0x8000 (line 1024) → no stored line changes. Read 0x8000 → readData=0. Host read 0x8000 → `host_rdata`=0.
- **Reset mid-host-read:** accept a host read at edge N and assert reset in cycle N+1 → `host_rvalid` stays 0. After reset, the previously written contents remain readable.

Source files
------------

// File: rtl/simd_mem_pkg.sv
// Shared types and helpers for the SIMD data memory.
package simd_mem_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 32;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [31:0]       byteen_t;

  typedef enum logic {IDLE, RESP} host_state_e;

  // Decoded line selection: index plus in-range flag.
  typedef struct packed {
    logic        ok;
    logic [31:0] idx;
  } line_sel_t;

  // Line index is addr[addr_w+4:5]; any set bit above that, or an index
  // at or beyond depth, marks the address out of range.
  function automatic line_sel_t line_idx(input logic [31:0] addr,
                                         input int unsigned addr_w,
                                         input int unsigned depth);
    line_sel_t r;
    r.idx = {5'd0, addr[31:5]};
    r.ok  = ((addr >> (addr_w + 5)) == 32'd0) && (r.idx < depth);
    return r;
  endfunction

endpackage

// File: rtl/simd_mem_lane.sv
// One 32-bit x DEPTH lane: byte-enabled write, two read-first registered
// read ports sharing the single address (processor port a, host port b).
module simd_mem_lane #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              rd_a,
  input  logic              zero_a,
  input  logic              rd_b,
  input  logic              zero_b,
  output logic [31:0]       rdata_a,
  output logic [31:0]       rdata_b
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_a_q;
  logic [31:0] rdata_b_q;

  // Byte-enabled write; gating for range and reset is done by the caller.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read registers; non-blocking update gives read-first on collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (rd_a) rdata_a_q <= zero_a ? 32'd0 : mem[addr];
      if (rd_b) rdata_b_q <= zero_b ? 32'd0 : mem[addr];
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/simd_data_mem.sv
// 256-bit SIMD data memory responder with an optional low-priority 32-bit
// host port. Host port is compiled only when SIMD_DATA_MEM_HOST_EN is defined;
// otherwise host outputs are tied to 0 and host inputs are ignored.
module simd_data_mem
  import simd_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address_RAM,
  input  byteen_t       byteena_RAM,
  input  line_t         writeData_RAM,
  input  logic          rden_RAM,
  input  logic          wren_RAM,
  output line_t         readData_RAM,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [31:0]   host_addr,
  input  logic [31:0]   host_wdata,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata
);

  line_sel_t         proc_sel;
  logic              proc_active;
  logic              proc_we;
  logic [ADDR_W-1:0] line_addr;

  logic [LANES-1:0]  lane_we;
  logic [3:0]        lane_be     [LANES];
  logic [31:0]       lane_wdata  [LANES];
  logic [LANES-1:0]  lane_zero_b;
  logic              lane_rd_b;
  logic [31:0]       lane_rdata_a [LANES];
  logic [31:0]       lane_rdata_b [LANES];
  logic [31:0]       host_or;
  logic              sel_unused;

  assign proc_sel    = line_idx(address_RAM, ADDR_W, DEPTH);
  assign proc_active = rden_RAM | wren_RAM;
  // Writes at a reset edge and out-of-range writes are dropped.
  assign proc_we     = wren_RAM && proc_sel.ok && !reset;

`ifdef SIMD_DATA_MEM_HOST_EN
  line_sel_t   host_sel;
  logic [2:0]  host_lane;
  logic        host_acc;
  logic        host_wr;
  logic        host_rd;
  host_state_e state_q;
  logic        rvalid_q;

  assign host_sel   = line_idx(host_addr, ADDR_W, DEPTH);
  assign host_lane  = host_addr[4:2];
  assign host_ready = !reset && !proc_active && (state_q == IDLE);
  assign host_acc   = host_req && host_ready;
  assign host_wr    = host_acc && host_we && host_sel.ok;
  assign host_rd    = host_acc && !host_we;
  assign lane_rd_b  = host_rd;
  assign line_addr  = proc_active ? proc_sel.idx[ADDR_W-1:0] : host_sel.idx[ADDR_W-1:0];

  // Host response FSM: one RESP cycle after each accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (host_rd) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
          end
        end
        RESP: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // A read accepted just before reset must not show its response.
  assign host_rvalid = rvalid_q && !reset;
  assign host_rdata  = host_or;
  assign sel_unused  = ^{proc_sel.idx[31:ADDR_W], host_sel.idx[31:ADDR_W]};
`else
  logic host_unused;

  assign line_addr   = proc_sel.idx[ADDR_W-1:0];
  assign lane_rd_b   = 1'b0;
  assign host_ready  = 1'b0;
  assign host_rvalid = 1'b0;
  assign host_rdata  = 32'd0;
  assign host_unused = ^{host_req, host_we, host_addr, host_wdata, host_or};
  assign sel_unused  = ^proc_sel.idx[31:ADDR_W];
`endif

  // Per-lane write controls: processor owns the port whenever it is active.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_we[k]     = proc_we;
      lane_be[k]     = byteena_RAM[4*k +: 4];
      lane_wdata[k]  = writeData_RAM[32*k +: 32];
      lane_zero_b[k] = 1'b1;
`ifdef SIMD_DATA_MEM_HOST_EN
      if (!proc_active) begin
        lane_we[k]    = host_wr && (host_lane == 3'(k));
        lane_be[k]    = 4'hF;
        lane_wdata[k] = host_wdata;
      end
      // Only the selected lane loads data; the rest load 0 so an OR picks the word.
      lane_zero_b[k] = !host_sel.ok || (host_lane != 3'(k));
`endif
    end
  end

  // Gather lanes into the processor line and the host word.
  always_comb begin
    host_or = 32'd0;
    for (int k = 0; k < LANES; k++) begin
      readData_RAM[32*k +: 32] = lane_rdata_a[k];
      host_or = host_or | lane_rdata_b[k];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_mem_lane #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .addr    (line_addr),
      .we      (lane_we[g]),
      .be      (lane_be[g]),
      .wdata   (lane_wdata[g]),
      .rd_a    (rden_RAM),
      .zero_a  (!proc_sel.ok),
      .rd_b    (lane_rd_b),
      .zero_b  (lane_zero_b[g]),
      .rdata_a (lane_rdata_a[g]),
      .rdata_b (lane_rdata_b[g])
    );
  end

endmodule
